// File: rtl/obi_pkg.sv
// -----------------------------------------------------------------------------
// obi_pkg
//   Shared OBI request/response types used by the cpu_subsystem core ports.
//   obi_req_t  : req, we, be, addr, wdata   (core/manager -> bus)
//   obi_resp_t : gnt, rvalid, rdata         (bus -> core/manager)
// -----------------------------------------------------------------------------
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage : obi_pkg

// File: rtl/cpu_obi_slice.sv
// -----------------------------------------------------------------------------
// cpu_obi_slice
//   OBI register slice between a core port (instr or data) and the system bus.
//   Registers the request in a one-entry hold register, optionally registers
//   the response, and limits granted-but-unanswered transactions to
//   MAX_OUTSTANDING.
//
// Ports
//   clk_i        in   clock
//   rst_ni       in   asynchronous active-low reset (shared with the bus)
//   core_req_i   in   request from core
//   core_resp_o  out  gnt / rvalid / rdata to core
//   bus_req_o    out  request to system bus (driven from the hold register)
//   bus_resp_i   in   gnt / rvalid / rdata from system bus
//   busy_o       out  high while transactions are outstanding or hold is full
// -----------------------------------------------------------------------------
module cpu_obi_slice
    import obi_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter bit          REG_RESP        = 1'b1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  obi_req_t  core_req_i,
    output obi_resp_t core_resp_o,
    output obi_req_t  bus_req_o,
    input  obi_resp_t bus_resp_i,
    output logic      busy_o
);

    localparam int unsigned     CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic             hold_valid_q;
    logic             hold_we_q;
    logic [3:0]       hold_be_q;
    logic [31:0]      hold_addr_q;
    logic [31:0]      hold_wdata_q;
    logic [CNT_W-1:0] out_cnt_q;

    logic             core_gnt;
    logic             rsp_rvalid;
    logic [31:0]      rsp_rdata;

    // The hold slot is free either when empty or when the bus takes its
    // current content this cycle, which allows one request per cycle.
    assign core_gnt = core_req_i.req
                    & (out_cnt_q < CNT_MAX)
                    & (~hold_valid_q | bus_resp_i.gnt);

    // ---------------------------------------------------------------- hold
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_valid_q <= 1'b0;
            hold_we_q    <= 1'b0;
            hold_be_q    <= '0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
        end else if (core_gnt) begin
            hold_valid_q <= 1'b1;
            hold_we_q    <= core_req_i.we;
            hold_be_q    <= core_req_i.be;
            hold_addr_q  <= core_req_i.addr;
            hold_wdata_q <= core_req_i.wdata;
        end else if (bus_resp_i.gnt) begin
            hold_valid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------- credits
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_cnt_q <= '0;
        end else begin
            case ({core_gnt, bus_resp_i.rvalid})
                2'b10:   out_cnt_q <= out_cnt_q + CNT_W'(1);
                // A stray rvalid at zero is flagged below; never wrap.
                2'b01:   if (out_cnt_q != '0) out_cnt_q <= out_cnt_q - CNT_W'(1);
                default: out_cnt_q <= out_cnt_q;
            endcase
        end
    end

    // ------------------------------------------------------------ response
    if (REG_RESP) begin : g_reg_resp
        logic        rvalid_q;
        logic [31:0] rdata_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= bus_resp_i.rvalid;
                if (bus_resp_i.rvalid) rdata_q <= bus_resp_i.rdata;
            end
        end

        assign rsp_rvalid = rvalid_q;
        assign rsp_rdata  = rdata_q;
    end else begin : g_comb_resp
        assign rsp_rvalid = bus_resp_i.rvalid;
        assign rsp_rdata  = bus_resp_i.rdata;
    end

    // ------------------------------------------------------------- outputs
    always_comb begin
        core_resp_o        = '0;
        core_resp_o.gnt    = core_gnt;
        core_resp_o.rvalid = rsp_rvalid;
        core_resp_o.rdata  = rsp_rdata;
    end

    always_comb begin
        bus_req_o       = '0;
        bus_req_o.req   = hold_valid_q;
        bus_req_o.we    = hold_we_q;
        bus_req_o.be    = hold_be_q;
        bus_req_o.addr  = hold_addr_q;
        bus_req_o.wdata = hold_wdata_q;
    end

    assign busy_o = (out_cnt_q != '0) | hold_valid_q;

    // ---------------------------------------------------------- assertions
    a_bus_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus_req_o.req && !bus_resp_i.gnt) |=> $stable(bus_req_o));

    a_cnt_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_cnt_q <= CNT_MAX);

    a_no_stray_rvalid : assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus_resp_i.rvalid |-> (out_cnt_q != '0));

endmodule : cpu_obi_slice

// File: tb/tb_cpu_obi_slice.sv
// -----------------------------------------------------------------------------
// tb_cpu_obi_slice
//   Randomized core/bus traffic around cpu_obi_slice with a queue-based
//   reference: granted requests must appear on the bus in order with stable
//   fields, bus responses must reach the core in order one cycle later.
// -----------------------------------------------------------------------------
module tb_cpu_obi_slice;
    import obi_pkg::*;

    localparam int unsigned MAX = 2;
    localparam bit          REG = 1'b1;

    logic      clk_i  = 1'b0;
    logic      rst_ni = 1'b0;
    obi_req_t  core_req;
    obi_resp_t core_resp;
    obi_req_t  bus_req;
    obi_resp_t bus_resp;
    logic      busy;

    always #5 clk_i = ~clk_i;

    cpu_obi_slice #(
        .MAX_OUTSTANDING (MAX),
        .REG_RESP        (REG)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .core_req_i  (core_req),
        .core_resp_o (core_resp),
        .bus_req_o   (bus_req),
        .bus_resp_i  (bus_resp),
        .busy_o      (busy)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    // Reference state
    obi_req_t hold_q[$];     // requests granted to core, not yet taken by bus
    rsp_t     rsp_q[$];      // bus responses awaiting delivery to core
    int       outstanding = 0;
    int       pend_cnt    = 0; // accepted by bus, response not yet given
    bit       last_gnt    = 1'b0;
    bit       mon_en      = 1'b0;

    // Stimulus knobs
    int unsigned p_req = 0, p_gnt = 0, p_rv = 0;
    bit          use_fix_addr  = 1'b0;
    logic [31:0] fix_addr      = '0;
    bit          use_fix_rdata = 1'b0;
    logic [31:0] fix_rdata     = '0;

    logic exp_gnt, exp_rv;

    always @(posedge clk_i) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: evaluate the cycle's handshakes at the negative edge.
    always @(negedge clk_i) begin
        if (mon_en) begin
            exp_gnt = core_req.req && (outstanding < int'(MAX))
                      && (hold_q.size() == 0 || bus_resp.gnt);
            chk("core_gnt", core_resp.gnt, exp_gnt);
            chk("bus_req", bus_req.req, hold_q.size() != 0);
            if (bus_req.req && hold_q.size() != 0)
                chk("bus_fields", {bus_req.we, bus_req.be, bus_req.addr, bus_req.wdata},
                    {hold_q[0].we, hold_q[0].be, hold_q[0].addr, hold_q[0].wdata});
            chk("busy", busy, (outstanding != 0) || (hold_q.size() != 0));
            chk("out_cnt", dut.out_cnt_q, outstanding);

            if (bus_req.req && bus_resp.gnt) begin
                if (hold_q.size() != 0) void'(hold_q.pop_front());
                pend_cnt++;
            end
            if (core_req.req && core_resp.gnt) begin
                hold_q.push_back(core_req);
                outstanding++;
            end
            if (bus_resp.rvalid) begin
                rsp_q.push_back('{data: bus_resp.rdata, cyc: cycle});
                outstanding--;
                pend_cnt--;
            end

            exp_rv = (rsp_q.size() != 0) && (rsp_q[0].cyc + (REG ? 1 : 0) == cycle);
            chk("core_rvalid", core_resp.rvalid, exp_rv);
            if (exp_rv) begin
                chk("core_rdata", core_resp.rdata, rsp_q[0].data);
                void'(rsp_q.pop_front());
            end

            last_gnt = core_req.req && core_resp.gnt;
        end
    end

    // One cycle of core and bus behaviour, driven just after the clock edge.
    task automatic drive_cycle();
        @(posedge clk_i);
        #1;
        if (!core_req.req || last_gnt) begin
            if ($urandom_range(99) < p_req) begin
                core_req.req   = 1'b1;
                core_req.we    = use_fix_addr ? 1'b0 : 1'($urandom);
                core_req.be    = 4'($urandom);
                core_req.addr  = use_fix_addr ? fix_addr : ($urandom & 32'hFFFF_FFFC);
                core_req.wdata = $urandom;
            end else begin
                core_req = '0;
            end
        end
        bus_resp.gnt = ($urandom_range(99) < p_gnt);
        if (pend_cnt > 0 && $urandom_range(99) < p_rv) begin
            bus_resp.rvalid = 1'b1;
            bus_resp.rdata  = use_fix_rdata ? fix_rdata : $urandom;
        end else begin
            bus_resp.rvalid = 1'b0;
            bus_resp.rdata  = $urandom;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive_cycle();
    endtask

    task automatic set_knobs(input int unsigned r, input int unsigned g, input int unsigned v);
        p_req = r; p_gnt = g; p_rv = v;
    endtask

    task automatic drain(input string name);
        int k;
        set_knobs(0, 100, 100);
        k = 0;
        while ((outstanding != 0 || hold_q.size() != 0) && k < 50) begin
            drive_cycle();
            k++;
        end
        run(3);
        chk({name, "_drain_timeout"}, (k < 50), 1'b1);
    endtask

    initial begin
        int k;
        core_req = '0;
        bus_resp = '0;

        // Reset state
        #2;
        chk("rst_core_resp", core_resp, '0);
        chk("rst_bus_req", bus_req, '0);
        chk("rst_busy", busy, 1'b0);
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b1;
        mon_en = 1'b1;

        // Single read with known address and data
        use_fix_addr = 1'b1; fix_addr = 32'h0000_1000;
        use_fix_rdata = 1'b1; fix_rdata = 32'hDEAD_BEEF;
        set_knobs(100, 100, 100);
        drive_cycle();
        p_req = 0;
        run(6);
        use_fix_addr = 1'b0; use_fix_rdata = 1'b0;

        // Streaming: bus always grants, answers one cycle after acceptance
        set_knobs(100, 100, 100);
        run(12);
        drain("stream");

        // Credit stall then resume
        set_knobs(100, 100, 0);
        run(6);
        p_rv = 100;
        run(4);
        drain("stall");

        // Bus backpressure for five cycles, then release
        set_knobs(100, 0, 100);
        run(5);
        p_gnt = 100;
        run(4);
        drain("backpressure");

        // Random traffic
        for (int blk = 0; blk < 60; blk++) begin
            set_knobs($urandom_range(100), $urandom_range(100), $urandom_range(100));
            run(50);
        end
        drain("random");

        // Reset with the hold register full and two transactions outstanding
        set_knobs(100, 100, 0);
        k = 0;
        while (outstanding != 2 && k < 20) begin
            drive_cycle();
            @(negedge clk_i); #1;
            k++;
        end
        chk("prefill_timeout", (k < 20), 1'b1);
        p_gnt = 0;
        drive_cycle();
        @(negedge clk_i); #1;
        chk("pre_rst_cnt", dut.out_cnt_q, 2);
        chk("pre_rst_busy", busy, 1'b1);
        @(posedge clk_i); #2;
        mon_en   = 1'b0;
        core_req = '0;
        bus_resp = '0;
        rst_ni   = 1'b0;
        #1;
        chk("mid_rst_core_resp", core_resp, '0);
        chk("mid_rst_bus_req", bus_req, '0);
        chk("mid_rst_busy", busy, 1'b0);
        hold_q.delete();
        rsp_q.delete();
        outstanding = 0;
        pend_cnt    = 0;
        last_gnt    = 1'b0;
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b1;
        mon_en = 1'b1;
        set_knobs(100, 100, 100);
        drive_cycle();
        @(negedge clk_i); #1;
        chk("post_rst_first_gnt", last_gnt, 1'b1);

        // More random traffic after reset
        for (int blk = 0; blk < 10; blk++) begin
            set_knobs($urandom_range(100), $urandom_range(100), $urandom_range(100));
            run(50);
        end
        drain("final");
        chk("final_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_cpu_obi_slice
